// File: rtl/circle_pkg.sv
// Shared types, widths and helpers for the circle_1024_xy point generator.
package circle_pkg;

    localparam int unsigned ANGLE_W    = 10;
    localparam int unsigned COORD_W    = 8;
    localparam int unsigned MAG_W      = 9;
    localparam int unsigned TABLE_LAST = 256;

    typedef enum logic [1:0] {
        StIdle,
        StCalcX,
        StCalcY,
        StDone
    } state_e;

    // pi scaled by 2^30, used only to build the magnitude table at elaboration
    localparam longint PI_Q30 = 64'sd3373259426;

    // round(256 * sin(pi * k / 512)) via a fixed-point Taylor series
    function automatic logic [MAG_W-1:0] sin_mag(input int k);
        longint xr;
        longint x2;
        longint term;
        longint sum;
        xr   = (longint'(k) * PI_Q30) >>> 9;
        x2   = (xr * xr) >>> 30;
        term = xr;
        sum  = xr;
        for (int n = 1; n <= 7; n++) begin
            term = -((term * x2) / (longint'(1) << 30)) / longint'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return MAG_W'((sum * 256 + (longint'(1) << 29)) >>> 30);
    endfunction

    // Quadrant fold: returns {negate, table index}
    function automatic logic [MAG_W:0] fold_phase(input logic [ANGLE_W-1:0] phase);
        logic [MAG_W-1:0] k;
        k = phase[8] ? (MAG_W'(TABLE_LAST) - {1'b0, phase[7:0]}) : {1'b0, phase[7:0]};
        return {phase[9], k};
    endfunction

endpackage

// File: rtl/circle_sin_rom.sv
// Combinational quarter-wave magnitude table, M(k) = round(256*sin(pi*k/512)), k = 0..256.
module circle_sin_rom
    import circle_pkg::*;
(
    input  logic [MAG_W-1:0] k_i,
    output logic [MAG_W-1:0] mag_o
);

    logic [MAG_W-1:0] table_w [TABLE_LAST+1];

    for (genvar i = 0; i <= int'(TABLE_LAST); i++) begin : g_tab
        assign table_w[i] = sin_mag(i);
    end

    always_comb begin
        mag_o = '0;
        if (k_i <= MAG_W'(TABLE_LAST)) begin
            mag_o = table_w[k_i];
        end
    end

endmodule

// File: rtl/circle_1024_xy.sv
// One circle point per req/ack transaction using a single shared 8x9 multiplier.
// Define CIRCLE_1024_SATURATE_EN to clamp results to 0..255 instead of wrapping.
module circle_1024_xy
    import circle_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic [ANGLE_W-1:0] angle,
    input  logic [COORD_W-1:0] r,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    input  logic               req_i,
    output logic               ack_o
);

    localparam int unsigned RES_W  = COORD_W + 2;
    localparam int unsigned PROD_W = COORD_W + MAG_W;

    state_e             state_q;
    logic [ANGLE_W-1:0] angle_q;
    logic [COORD_W-1:0] r_q, x0_q, y0_q, xh_q, x_q, y_q;
    logic               ack_q;

    logic [ANGLE_W-1:0] phase;
    logic               neg;
    logic [MAG_W-1:0]   k;
    logic [MAG_W-1:0]   mag;
    logic [PROD_W-1:0]  prod;
    logic [COORD_W-1:0] offset;
    logic [COORD_W-1:0] centre;
    logic [RES_W-1:0]   res;
    logic [COORD_W-1:0] coord;

    circle_sin_rom u_rom (
        .k_i  (k),
        .mag_o(mag)
    );

    // CALC_X evaluates cosine (phase advanced a quarter turn), CALC_Y evaluates sine
    always_comb begin
        phase    = (state_q == StCalcX) ? angle_q + ANGLE_W'(TABLE_LAST) : angle_q;
        {neg, k} = fold_phase(phase);
        prod     = PROD_W'(r_q) * PROD_W'(mag);
        offset   = COORD_W'((prod + PROD_W'(128)) >> 8);
        centre   = (state_q == StCalcX) ? x0_q : y0_q;
        res      = neg ? (RES_W'(centre) - RES_W'(offset)) : (RES_W'(centre) + RES_W'(offset));
`ifdef CIRCLE_1024_SATURATE_EN
        if (res[RES_W-1]) begin
            coord = '0;
        end else if (res[COORD_W]) begin
            coord = '1;
        end else begin
            coord = res[COORD_W-1:0];
        end
`else
        coord = res[COORD_W-1:0];
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            angle_q <= '0;
            r_q     <= '0;
            x0_q    <= '0;
            y0_q    <= '0;
            xh_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            ack_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_i) begin
                        angle_q <= angle;
                        r_q     <= r;
                        x0_q    <= x0;
                        y0_q    <= y0;
                        state_q <= StCalcX;
                    end
                end
                StCalcX: begin
                    xh_q    <= coord;
                    state_q <= StCalcY;
                end
                // Outputs load together on entry to DONE so the pair stays coherent
                StCalcY: begin
                    x_q     <= xh_q;
                    y_q     <= coord;
                    ack_q   <= 1'b1;
                    state_q <= StDone;
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign x     = x_q;
    assign y     = y_q;
    assign ack_o = ack_q;

endmodule

// File: tb/tb_circle_1024_xy.sv
// Directed self-checking bench for circle_1024_xy.
module tb_circle_1024_xy;

    logic       clock = 1'b0;
    logic       reset;
    logic [9:0] angle;
    logic [7:0] r, x0, y0, x, y;
    logic       req_i, ack_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    circle_1024_xy dut (
        .clock(clock),
        .reset(reset),
        .angle(angle),
        .r    (r),
        .x0   (x0),
        .y0   (y0),
        .x    (x),
        .y    (y),
        .req_i(req_i),
        .ack_o(ack_o)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One transaction with exact latency checks; inputs are scrambled after capture
    task automatic point(input string tag, input logic [9:0] a, input logic [7:0] rr,
                         input logic [7:0] xx, input logic [7:0] yy,
                         input logic [7:0] ex, input logic [7:0] ey);
        @(negedge clock);
        angle = a; r = rr; x0 = xx; y0 = yy; req_i = 1'b1;
        @(posedge clock); #1;
        angle = ~a; r = ~rr; x0 = ~xx; y0 = ~yy;
        check({tag, " ack N"}, 32'(ack_o), 0);
        @(posedge clock); #1;
        req_i = 1'b0;
        check({tag, " ack N+1"}, 32'(ack_o), 0);
        @(posedge clock); #1;
        check({tag, " ack N+2"}, 32'(ack_o), 1);
        check({tag, " x"}, 32'(x), 32'(ex));
        check({tag, " y"}, 32'(y), 32'(ey));
        @(posedge clock); #1;
        check({tag, " ack N+3"}, 32'(ack_o), 0);
        check({tag, " x held"}, 32'(x), 32'(ex));
    endtask

    initial begin
        int acks;
        int last;
        int dx;
        int dy;
        int d;
        bit got;

        reset = 1'b1; req_i = 1'b0; angle = '0; r = '0; x0 = '0; y0 = '0;
        #1;
        check("reset x", 32'(x), 0);
        check("reset y", 32'(y), 0);
        check("reset ack", 32'(ack_o), 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        point("a0",   10'd0,   8'd120, 8'd120, 8'd128, 8'd240, 8'd128);
        point("a256", 10'd256, 8'd120, 8'd120, 8'd128, 8'd120, 8'd248);
        point("a512", 10'd512, 8'd120, 8'd120, 8'd128, 8'd0,   8'd128);
        point("a768", 10'd768, 8'd120, 8'd120, 8'd128, 8'd120, 8'd8);
        point("a128", 10'd128, 8'd120, 8'd120, 8'd128, 8'd205, 8'd213);
        point("a640", 10'd640, 8'd120, 8'd120, 8'd128, 8'd35,  8'd43);
        point("r0",   10'd300, 8'd0,   8'd77,  8'd99,  8'd77,  8'd99);
`ifdef CIRCLE_1024_SATURATE_EN
        point("ovf", 10'd0, 8'd100, 8'd200, 8'd50, 8'd255, 8'd50);
`else
        point("ovf", 10'd0, 8'd100, 8'd200, 8'd50, 8'd44, 8'd50);
`endif

        // Reset during CALC_Y discards the transaction
        @(negedge clock);
        angle = 10'd128; r = 8'd120; x0 = 8'd120; y0 = 8'd128; req_i = 1'b1;
        @(posedge clock); #1;
        req_i = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        check("midrst x", 32'(x), 0);
        check("midrst y", 32'(y), 0);
        check("midrst ack", 32'(ack_o), 0);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            check("midrst no ack", 32'(ack_o), 0);
        end
        point("postrst", 10'd256, 8'd120, 8'd120, 8'd128, 8'd120, 8'd248);

        // Full sweep with req held high
        acks = 0;
        last = 0;
        @(negedge clock);
        angle = 10'd0; r = 8'd120; x0 = 8'd120; y0 = 8'd128; req_i = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            got = 1'b0;
            for (int w = 0; w < 8 && !got; w++) begin
                @(posedge clock); #1;
                if (ack_o) got = 1'b1;
            end
            if (!got) begin
                check("sweep timeout", 0, 1);
                break;
            end
            acks++;
            if (i > 0) check("sweep spacing", 32'(cyc - last), 4);
            last = cyc;
            dx = int'(x) - 120;
            dy = int'(y) - 128;
            d  = dx * dx + dy * dy;
            check("sweep radius", 32'(d >= 14400 - 240 && d <= 14400 + 240), 1);
            angle = angle + 10'd1;
        end
        req_i = 1'b0;
        check("sweep acks", 32'(acks), 1024);
        repeat (4) @(posedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
